// File: rtl/muldiv_ctrl.sv
// RV32M sequencing front-end for an unsigned mul_div engine: resolves operand signs,
// short-circuits divide-by-zero and signed overflow, and fixes result signs afterwards.
module muldiv_ctrl (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [2:0]  req_funct3,
  input  logic [31:0] req_rs1,
  input  logic [31:0] req_rs2,
  input  logic [4:0]  req_rd,
  output logic [1:0]  md_op,
  output logic [31:0] md_rs1,
  output logic [31:0] md_rs2,
  output logic        md_rs1_signed,
  output logic        md_rs2_signed,
  input  logic [31:0] md_high,
  input  logic [31:0] md_low,
  input  logic        md_ready,
  output logic        wb_valid,
  input  logic        wb_ready,
  output logic [4:0]  wb_rd,
  output logic [31:0] wb_data,
  output logic        busy
);

  typedef enum logic [1:0] {StIdle, StRun, StFix, StDone} state_e;

  localparam logic [1:0] OpIdle = 2'd0;
  localparam logic [1:0] OpMul  = 2'd1;
  localparam logic [1:0] OpDiv  = 2'd2;

  state_e      state_q;
  logic [2:0]  funct3_q;
  logic [4:0]  rd_q;
  logic        neg1_q, neg2_q;
  logic [31:0] md_rs1_q, md_rs2_q;
  logic [1:0]  md_op_q;
  logic [31:0] hi_q, lo_q;
  logic [31:0] wb_data_q;
  logic [4:0]  wb_rd_q;
  logic        wb_valid_q;
  logic        req_ready_q;
  logic        busy_q;

  // Request decode, evaluated on the accept edge
  logic        rs1_signed, rs2_signed;
  logic        neg1, neg2;
  logic [31:0] mag1, mag2;
  logic        is_div, div_zero, div_ovf, special;
  logic [31:0] special_data;

  always_comb begin
    rs1_signed   = req_funct3 inside {3'd1, 3'd2, 3'd4, 3'd6};
    rs2_signed   = req_funct3 inside {3'd1, 3'd4, 3'd6};
    neg1         = rs1_signed & req_rs1[31];
    neg2         = rs2_signed & req_rs2[31];
    mag1         = neg1 ? (32'd0 - req_rs1) : req_rs1;
    mag2         = neg2 ? (32'd0 - req_rs2) : req_rs2;
    is_div       = req_funct3[2];
    div_zero     = is_div && (req_rs2 == 32'd0);
    div_ovf      = is_div && !req_funct3[0] && (req_rs1 == 32'h8000_0000) &&
                   (req_rs2 == 32'hFFFF_FFFF);
    special      = div_zero || div_ovf;
    special_data = 32'd0;
    if (div_zero) begin
      special_data = req_funct3[1] ? req_rs1 : 32'hFFFF_FFFF;
    end else if (div_ovf) begin
      special_data = req_funct3[1] ? 32'd0 : 32'h8000_0000;
    end
  end

  // Sign fix-up of the raw unsigned engine result
  logic [63:0] prod, prod_fix;
  logic [31:0] quot_fix, rem_fix;
  logic [31:0] fix_data;

  always_comb begin
    prod     = {hi_q, lo_q};
    prod_fix = (neg1_q ^ neg2_q) ? (64'd0 - prod) : prod;
    // Unsigned variants never set the neg flags, so only the quotient/remainder split matters
    quot_fix = (!funct3_q[1] && (neg1_q ^ neg2_q)) ? (32'd0 - lo_q) : lo_q;
    rem_fix  = (funct3_q[1] && neg1_q) ? (32'd0 - hi_q) : hi_q;
    fix_data = 32'd0;
    if (!funct3_q[2]) begin
      fix_data = (funct3_q[1:0] == 2'd0) ? prod_fix[31:0] : prod_fix[63:32];
    end else begin
      fix_data = funct3_q[1] ? rem_fix : quot_fix;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= StIdle;
      funct3_q    <= 3'd0;
      rd_q        <= 5'd0;
      neg1_q      <= 1'b0;
      neg2_q      <= 1'b0;
      md_rs1_q    <= 32'd0;
      md_rs2_q    <= 32'd0;
      md_op_q     <= OpIdle;
      hi_q        <= 32'd0;
      lo_q        <= 32'd0;
      wb_data_q   <= 32'd0;
      wb_rd_q     <= 5'd0;
      wb_valid_q  <= 1'b0;
      req_ready_q <= 1'b1;
      busy_q      <= 1'b0;
    end else begin
      case (state_q)
        StIdle: begin
          if (req_valid) begin
            funct3_q    <= req_funct3;
            rd_q        <= req_rd;
            neg1_q      <= neg1;
            neg2_q      <= neg2;
            md_rs1_q    <= mag1;
            md_rs2_q    <= mag2;
            req_ready_q <= 1'b0;
            busy_q      <= 1'b1;
            if (special) begin
              wb_data_q  <= special_data;
              wb_rd_q    <= req_rd;
              wb_valid_q <= 1'b1;
              state_q    <= StDone;
            end else begin
              md_op_q <= is_div ? OpDiv : OpMul;
              state_q <= StRun;
            end
          end
        end
        StRun: begin
          if (md_ready) begin
            hi_q    <= md_high;
            lo_q    <= md_low;
            md_op_q <= OpIdle;
            state_q <= StFix;
          end
        end
        StFix: begin
          wb_data_q  <= fix_data;
          wb_rd_q    <= rd_q;
          wb_valid_q <= 1'b1;
          state_q    <= StDone;
        end
        StDone: begin
          if (wb_ready) begin
            wb_valid_q  <= 1'b0;
            req_ready_q <= 1'b1;
            busy_q      <= 1'b0;
            state_q     <= StIdle;
          end
        end
        default: begin
          md_op_q     <= OpIdle;
          wb_valid_q  <= 1'b0;
          req_ready_q <= 1'b1;
          busy_q      <= 1'b0;
          state_q     <= StIdle;
        end
      endcase
    end
  end

  assign req_ready     = req_ready_q;
  assign md_op         = md_op_q;
  assign md_rs1        = md_rs1_q;
  assign md_rs2        = md_rs2_q;
  assign md_rs1_signed = 1'b0;
  assign md_rs2_signed = 1'b0;
  assign wb_valid      = wb_valid_q;
  assign wb_rd         = wb_rd_q;
  assign wb_data       = wb_data_q;
  assign busy          = busy_q;

endmodule
